uart_tx_arbiter: RTL and testbench

Shares one UART TX core between N byte requesters. Round-robin picks a requester, captures its byte and the parity configuration, and issues a one-cycle Data_Valid launch into the TX core. It then tracks the core's busy flag until the frame completes, with a timeout in case busy never asserts. It sits between the system-side byte sources and the TX core's P_DATA/Data_Valid/PAR_EN/PAR_TYP/busy interface.

---
 rtl/uart_tx_arb_pkg.sv | 36 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 51 +++++
 rtl/uart_tx_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_arb_pkg
// Shared definitions for the UART TX arbiter:
//   arb_state_t  - arbiter FSM states (also exported on the debug port)
//   PAR_EVEN/ODD - encoding of the PAR_TYP line towards the TX core
//   timer_width  - width of the shared busy-timeout / gap counter
// ----------------------------------------------------------------------------
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } arb_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // One counter serves both the busy timeout and the inter-frame gap, so it
    // must hold the larger of the two limits plus one (the gap count runs one
    // past its last value on the cycle it hands back to IDLE).
    function automatic int timer_width(input int busy_timeout, input int gap_cycles);
        int span;
        span = busy_timeout;
        if (gap_cycles > span) begin
            span = gap_cycles;
        end
        if (span < 1) begin
            span = 1;
        end
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// uart_rr_pick
// Purely combinational round-robin search. Starting one position above
// last_grant and wrapping around, the first asserted request wins.
// Ports:
//   req        in  N_REQ  request vector
//   last_grant in  IW     index granted most recently
//   win        out IW     winning index (only meaningful when any_req=1)
//   any_req    out 1      at least one request asserted
// ----------------------------------------------------------------------------
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [IW-1:0]    win,
    output logic             any_req
);

    logic [IW-1:0] win_hi;
    logic [IW-1:0] win_lo;
    logic          hit_hi;
    logic          hit_lo;

    // Requests strictly above last_grant outrank those at or below it (the
    // wrapped part of the scan). Walking downwards leaves the lowest index of
    // each group in win_hi / win_lo.
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IW'(i) > last_grant) begin
                    win_hi = IW'(i);
                    hit_hi = 1'b1;
                end else begin
                    win_lo = IW'(i);
                    hit_lo = 1'b1;
                end
            end
        end
        win     = hit_hi ? win_hi : win_lo;
        any_req = hit_hi | hit_lo;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART TX core between N_REQ byte requesters. A round-robin pick
// accepts one byte plus the parity configuration, launches it into the core
// with a single Data_Valid strobe, then follows the core's busy flag until the
// frame ends (or until busy fails to rise within BUSY_TIMEOUT cycles).
//
// Handshakes:
//   req_valid/req_ready - byte i is consumed in the cycle where both
//     req_valid[i] and req_ready[i] are 1. req_ready is a one-hot,
//     combinational pulse that only occurs in IDLE while busy=0; it never
//     waits for, nor depends on, a later cycle. Dropping req_valid without an
//     accept is allowed.
//   Data_Valid/busy - Data_Valid is a one-cycle launch; the core answers by
//     raising busy and lowering it when the frame has been shifted out.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid[N]      per-requester byte available
//   req_data[8N]      per-requester byte, slice i = [8i+7:8i]
//   req_ready[N]      one-hot accept pulse
//   cfg_par_en/typ    parity configuration, sampled at accept
//   P_DATA, Data_Valid, PAR_EN, PAR_TYP   TX core launch interface
//   busy              TX core busy flag
//   grant_id          requester owning the current frame
//   frame_done        one-cycle pulse when busy falls after a launch
//   err_timeout       one-cycle pulse when busy never rose after a launch
//   fsm_state         arbiter state, for observation
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 0,
    localparam int IW          = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               cfg_par_en,
    input  logic               cfg_par_typ,
    output logic [7:0]         P_DATA,
    output logic               Data_Valid,
    output logic               PAR_EN,
    output logic               PAR_TYP,
    input  logic               busy,
    output logic [IW-1:0]      grant_id,
    output logic               frame_done,
    output logic               err_timeout,
    output arb_state_t         fsm_state
);

    localparam int              TMR_W        = timer_width(BUSY_TIMEOUT, GAP_CYCLES);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // With no gap configured the GAP state is never visited.
    localparam arb_state_t      AFTER_FRAME  = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [TMR_W-1:0] timer;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    win;
    logic             any_req;
    logic [7:0]       win_data;
    logic             accept;
    logic             end_frame;

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .win        (win),
        .any_req    (any_req)
    );

    // Byte of the winning requester.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IW'(i)) begin
                win_data = req_data[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        end_frame   = 1'b0;
        Data_Valid  = 1'b0;
        frame_done  = 1'b0;
        err_timeout = 1'b0;
        case (state)
            IDLE: begin
                // An externally busy core stalls arbitration; reset also
                // blocks the accept so no byte is consumed while held.
                if (!rst && any_req && !busy) begin
                    accept     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                Data_Valid = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_next = WAIT_DONE;
                end else if (timer == TIMEOUT_LAST) begin
                    err_timeout = 1'b1;
                    end_frame   = 1'b1;
                    state_next  = AFTER_FRAME;
                end
            end
            WAIT_DONE: begin
                // No timeout here: a core may legitimately stay busy for a
                // long frame.
                if (!busy) begin
                    frame_done = 1'b1;
                    end_frame  = 1'b1;
                    state_next = AFTER_FRAME;
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-hot accept towards the winning requester.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept && (win == IW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Launch registers, round-robin pointer and shared timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            P_DATA     <= '0;
            PAR_EN     <= 1'b0;
            PAR_TYP    <= PAR_EVEN;
            grant_id   <= '0;
            last_grant <= IW'(N_REQ - 1);
            timer      <= '0;
        end else begin
            // Everything the core sees is captured at accept and then held
            // until the next accept, so cfg changes mid-frame are ignored.
            if (accept) begin
                P_DATA   <= win_data;
                PAR_EN   <= cfg_par_en;
                PAR_TYP  <= cfg_par_typ;
                grant_id <= win;
            end
            // A timed-out frame still counts as a turn for fairness.
            if (end_frame) begin
                last_grant <= grant_id;
            end
            if (state == LAUNCH || end_frame) begin
                timer <= '0;
            end else if ((state == WAIT_BUSY && !busy) || state == GAP) begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench: a table of frames (request mask, data, parity config, core
// busy timing, expected winner and byte) plus hand-written sequences for the
// timeout, busy stall, mid-frame reset and inter-frame gap cases. A second
// instance with GAP_CYCLES=3 covers the gap and config isolation.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_tx_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- main DUT (GAP_CYCLES = 0) ----------------
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        cfg_par_en;
    logic        cfg_par_typ;
    logic [7:0]  P_DATA;
    logic        Data_Valid;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        busy;
    logic [1:0]  grant_id;
    logic        frame_done;
    logic        err_timeout;
    arb_state_t  fsm_state;

    uart_tx_arbiter #(
        .N_REQ        (4),
        .BUSY_TIMEOUT (16),
        .GAP_CYCLES   (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_typ (cfg_par_typ),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .busy        (busy),
        .grant_id    (grant_id),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .fsm_state   (fsm_state)
    );

    // ---------------- gap DUT (GAP_CYCLES = 3) ----------------
    logic [3:0]  req_valid_g;
    logic [31:0] req_data_g;
    logic [3:0]  req_ready_g;
    logic        cfg_par_en_g;
    logic        cfg_par_typ_g;
    logic [7:0]  P_DATA_g;
    logic        Data_Valid_g;
    logic        PAR_EN_g;
    logic        PAR_TYP_g;
    logic        busy_g;
    logic [1:0]  grant_id_g;
    logic        frame_done_g;
    logic        err_timeout_g;
    arb_state_t  fsm_state_g;

    uart_tx_arbiter #(
        .N_REQ        (4),
        .BUSY_TIMEOUT (16),
        .GAP_CYCLES   (3)
    ) dut_gap (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid_g),
        .req_data    (req_data_g),
        .req_ready   (req_ready_g),
        .cfg_par_en  (cfg_par_en_g),
        .cfg_par_typ (cfg_par_typ_g),
        .P_DATA      (P_DATA_g),
        .Data_Valid  (Data_Valid_g),
        .PAR_EN      (PAR_EN_g),
        .PAR_TYP     (PAR_TYP_g),
        .busy        (busy_g),
        .grant_id    (grant_id_g),
        .frame_done  (frame_done_g),
        .err_timeout (err_timeout_g),
        .fsm_state   (fsm_state_g)
    );

    // ---------------- scoreboard ----------------
    int         total;
    int         bad;
    int         fd_cnt;
    int         err_cnt;
    int         exp_fd;
    logic [7:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every launch must carry the next expected byte, exactly once.
    always @(negedge clk) begin
        if (!rst) begin
            if (Data_Valid) begin
                check("dv_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("dv_byte", P_DATA, exp_q.pop_front());
                end
            end
            if (frame_done) fd_cnt++;
            if (err_timeout) err_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        logic        pe;
        logic        pt;
        int          dly;
        int          len;
        int          exp_g;
        logic [7:0]  exp_b;
    } vec_t;

    vec_t tbl[14];

    // ---------------- driver tasks ----------------
    // Raise the requests, expect the accept on exp_g, then check the launch.
    // Ends at the negedge of the LAUNCH cycle.
    task automatic accept_launch(input logic [3:0] mask, input logic [31:0] data,
                                 input logic pe, input logic pt,
                                 input int exp_g, input logic [7:0] exp_b);
        bit got;
        @(posedge clk); #1;
        busy        = 1'b0;
        req_valid   = mask;
        req_data    = data;
        cfg_par_en  = pe;
        cfg_par_typ = pt;
        exp_q.push_back(exp_b);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready != 4'd0) begin
                got = 1'b1;
                check("req_ready", req_ready, 32'd1 << exp_g);
            end
        end
        check("accept_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        // Flip config straight after the accept; the launch must not see it.
        cfg_par_en  = ~pe;
        cfg_par_typ = ~pt;
        @(negedge clk);
        check("launch_dv", Data_Valid, 32'd1);
        check("launch_grant", grant_id, exp_g);
        check("launch_par_en", PAR_EN, pe);
        check("launch_par_typ", PAR_TYP, pt);
        check("launch_ready", req_ready, 32'd0);
    endtask

    // Core model: busy rises dly cycles after Data_Valid and stays len cycles.
    task automatic busy_phase(input int dly, input int len, input int exp_g, input logic [7:0] exp_b);
        for (int k = 0; k < dly; k++) begin
            @(posedge clk); #1;
        end
        busy = 1'b1;
        for (int k = 0; k < len - 1; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("wait_done_state", fsm_state, WAIT_DONE);
        check("ready_in_frame", req_ready, 32'd0);
        @(posedge clk); #1;
        busy      = 1'b0;
        req_valid = 4'd0;
        exp_fd++;
        @(negedge clk);
        check("frame_done_pulse", frame_done, 32'd1);
        check("done_grant", grant_id, exp_g);
        check("done_pdata", P_DATA, exp_b);
        check("done_no_err", err_timeout, 32'd0);
        @(negedge clk);
        check("frame_done_end", frame_done, 32'd0);
        check("idle_after_done", fsm_state, IDLE);
    endtask

    task automatic do_frame(input vec_t v);
        accept_launch(v.mask, v.data, v.pe, v.pt, v.exp_g, v.exp_b);
        busy_phase(v.dly, v.len, v.exp_g, v.exp_b);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int first_err;
        int err_before;
        int fd_before;
        int acc_at;
        logic [31:0] l_dv, l_pd, l_pe, l_pt, l_gid, l_rdy;

        total = 0; bad = 0; fd_cnt = 0; err_cnt = 0; exp_fd = 0;

        // Fairness from reset, single request, wrap-around and mixed masks.
        tbl[0]  = '{4'hF, 32'h13121110, 1'b0, 1'b0, 2, 3,   0, 8'h10};
        tbl[1]  = '{4'hF, 32'h13121110, 1'b1, 1'b0, 2, 3,   1, 8'h11};
        tbl[2]  = '{4'hF, 32'h13121110, 1'b0, 1'b1, 2, 3,   2, 8'h12};
        tbl[3]  = '{4'hF, 32'h13121110, 1'b1, 1'b1, 2, 3,   3, 8'h13};
        tbl[4]  = '{4'hF, 32'h13121110, 1'b0, 1'b0, 2, 3,   0, 8'h10};
        tbl[5]  = '{4'hF, 32'h13121110, 1'b1, 1'b0, 2, 3,   1, 8'h11};
        tbl[6]  = '{4'hF, 32'h13121110, 1'b0, 1'b1, 2, 3,   2, 8'h12};
        tbl[7]  = '{4'hF, 32'h13121110, 1'b1, 1'b1, 2, 3,   3, 8'h13};
        tbl[8]  = '{4'h4, 32'h13A51110, 1'b1, 1'b1, 2, 110, 2, 8'hA5};
        tbl[9]  = '{4'h8, 32'h13121110, 1'b0, 1'b1, 2, 3,   3, 8'h13};
        tbl[10] = '{4'hA, 32'h13121110, 1'b1, 1'b0, 2, 3,   1, 8'h11};
        tbl[11] = '{4'hA, 32'h13121110, 1'b0, 1'b0, 2, 3,   3, 8'h13};
        tbl[12] = '{4'h3, 32'h13121110, 1'b1, 1'b1, 1, 2,   0, 8'h10};
        tbl[13] = '{4'h3, 32'h13121110, 1'b1, 1'b0, 3, 4,   1, 8'h11};

        // Reset with every request raised: nothing may be accepted.
        rst = 1'b1;
        busy = 1'b0; req_valid = 4'hF; req_data = 32'h13121110;
        cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        busy_g = 1'b0; req_valid_g = 4'h0; req_data_g = 32'h44332211;
        cfg_par_en_g = 1'b0; cfg_par_typ_g = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pdata", P_DATA, 32'd0);
        check("rst_dv", Data_Valid, 32'd0);
        check("rst_par_en", PAR_EN, 32'd0);
        check("rst_par_typ", PAR_TYP, 32'd0);
        check("rst_ready", req_ready, 32'd0);
        check("rst_grant", grant_id, 32'd0);
        check("rst_done", frame_done, 32'd0);
        check("rst_err", err_timeout, 32'd0);
        check("rst_state", fsm_state, IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'h0;

        foreach (tbl[i]) begin
            do_frame(tbl[i]);
        end

        // Timeout: busy never rises; err_timeout 16 cycles after LAUNCH.
        err_before = err_cnt;
        fd_before  = fd_cnt;
        accept_launch(4'h1, 32'h13121110, 1'b1, 1'b0, 0, 8'h10);
        @(posedge clk); #1;
        req_valid = 4'h0;
        first_err = -1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (err_timeout && first_err < 0) first_err = c;
        end
        check("timeout_cycle", first_err, 32'd16);
        check("timeout_pulses", err_cnt - err_before, 32'd1);
        check("timeout_no_done", fd_cnt - fd_before, 32'd0);
        // The timed-out requester 0 counts as served: requester 1 is next.
        do_frame('{4'h2, 32'h13121110, 1'b0, 1'b1, 2, 3, 1, 8'h11});

        // Core externally busy in IDLE: no accept until busy drops.
        @(posedge clk); #1;
        busy = 1'b1;
        req_valid = 4'h4;
        acc_at = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (req_ready != 4'd0) acc_at++;
        end
        check("stall_no_accept", acc_at, 32'd0);
        accept_launch(4'h4, 32'h13121110, 1'b1, 1'b1, 2, 8'h12);
        busy_phase(2, 3, 2, 8'h12);

        // Reset in WAIT_DONE abandons the frame; requester 0 served first.
        accept_launch(4'h8, 32'h13121110, 1'b1, 1'b1, 3, 8'h13);
        @(posedge clk); #1;
        busy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_reset_state", fsm_state, WAIT_DONE);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        check("mrst_pdata", P_DATA, 32'd0);
        check("mrst_dv", Data_Valid, 32'd0);
        check("mrst_par_en", PAR_EN, 32'd0);
        check("mrst_par_typ", PAR_TYP, 32'd0);
        check("mrst_ready", req_ready, 32'd0);
        check("mrst_grant", grant_id, 32'd0);
        check("mrst_done", frame_done, 32'd0);
        check("mrst_state", fsm_state, IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        busy = 1'b0;
        req_valid = 4'h0;
        do_frame('{4'hF, 32'h13121110, 1'b0, 1'b1, 2, 3, 0, 8'h10});

        // Gap instance: cfg toggled in WAIT_DONE, gap of 3 before next accept.
        @(posedge clk); #1;
        req_valid_g = 4'h1;
        cfg_par_en_g = 1'b1;
        cfg_par_typ_g = PAR_EVEN;
        @(negedge clk);
        check("gap_accept0", req_ready_g, 32'h1);
        @(posedge clk); #1;
        req_valid_g = 4'h0;
        @(negedge clk);
        check("gap_dv0", Data_Valid_g, 32'd1);
        check("gap_pdata0", P_DATA_g, 32'h11);
        @(posedge clk); #1;
        busy_g = 1'b1;
        @(posedge clk); #1;
        cfg_par_typ_g = PAR_ODD;
        cfg_par_en_g = 1'b0;
        req_valid_g = 4'h2;
        @(negedge clk);
        check("iso_par_typ_wd", PAR_TYP_g, PAR_EVEN);
        check("iso_par_en_wd", PAR_EN_g, 32'd1);
        @(posedge clk); #1;
        busy_g = 1'b0;
        @(negedge clk);
        check("gap_frame_done", frame_done_g, 32'd1);
        acc_at = -1;
        l_dv = 0; l_pd = 0; l_pe = 0; l_pt = 0; l_gid = 0; l_rdy = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (req_ready_g != 4'd0 && acc_at < 0) begin
                acc_at = c;
                l_rdy = 32'(req_ready_g);
            end
            if (c == 3) check("iso_par_typ_gap", PAR_TYP_g, PAR_EVEN);
            if (c == 5) begin
                l_dv = 32'(Data_Valid_g); l_pd = 32'(P_DATA_g);
                l_pe = 32'(PAR_EN_g); l_pt = 32'(PAR_TYP_g); l_gid = 32'(grant_id_g);
            end
        end
        req_valid_g = 4'h0;
        check("gap_accept_cycle", acc_at, 32'd4);
        check("gap_accept1", l_rdy, 32'h2);
        check("gap_dv1", l_dv, 32'd1);
        check("gap_pdata1", l_pd, 32'h22);
        check("gap_par_en1", l_pe, 32'd0);
        check("gap_par_typ1", l_pt, 32'(PAR_ODD));
        check("gap_grant1", l_gid, 32'd1);

        // ---------------- final report ----------------
        repeat (2) @(posedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        check("frame_done_total", fd_cnt, exp_fd);
        check("err_total", err_cnt, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
